sram_block_unpacker: RTL and testbench

Upstream feeder for the 8x8 byte block buffer. On `start`, it reads one 8x8 block of pixels from 16-bit SRAM: 32 words, 4 per row, with a programmable row stride. It splits each word into two bytes, high byte first, and writes each byte into the block buffer through `mem32_enb` / `r_data` / `in_icounter` / `in_jcounter`. It pulses `done` when the block is complete, and the buffer's packing stage can then start.

---
 rtl/sram_block_unpacker_pkg.sv | 19 +
 rtl/sram_block_unpacker_if.sv | 32 +++
 rtl/sram_block_unpacker_counterr.sv | 21 ++
 rtl/sram_block_unpacker.sv | 100 ++++++++++
 tb/tb_sram_block_unpacker.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_block_unpacker_pkg.sv
// rtl/sram_block_unpacker_pkg.sv - shared state encoding and block geometry
package sram_block_unpacker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD0,
      HI,
      LO,
      FIN
   } state_t;

   localparam int ROWS          = 8;
   localparam int COLS          = 8;
   localparam int WORDS_PER_ROW = 4;
   localparam int BYTE_W        = 8;
   localparam int ROW_W         = $clog2(ROWS);
   localparam int COL_W         = $clog2(COLS);

endpackage

// File: rtl/sram_block_unpacker_if.sv
// rtl/sram_block_unpacker_if.sv - SRAM read bus and block-buffer write bus
interface sram_block_unpacker_if #(
   parameter int AW = 18,
   parameter int DW = 16
);
   import sram_block_unpacker_pkg::*;

   logic              start;
   logic [AW-1:0]     base_addr;
   logic [AW-1:0]     sram_addr;
   logic              sram_ren;
   logic [DW-1:0]     sram_rdata;
   logic              mem32_enb;
   logic [BYTE_W-1:0] r_data;
   logic [ROW_W-1:0]  in_icounter;
   logic [COL_W-1:0]  in_jcounter;
   logic              busy;
   logic              done;

   modport master (
      input  start, base_addr, sram_rdata,
      output sram_addr, sram_ren, mem32_enb, r_data,
             in_icounter, in_jcounter, busy, done
   );

   modport slave (
      output start, base_addr, sram_rdata,
      input  sram_addr, sram_ren, mem32_enb, r_data,
             in_icounter, in_jcounter, busy, done
   );

endinterface

// File: rtl/sram_block_unpacker_counterr.sv
// rtl/sram_block_unpacker_counterr.sv - clearable wrapping up-counter
module sram_block_unpacker_counterr #(
   parameter int SIZE = 3
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            clear,
   input  logic            enable,
   output logic [SIZE-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable)
         count <= count + SIZE'(1);
   end

endmodule

// File: rtl/sram_block_unpacker.sv
// rtl/sram_block_unpacker.sv - reads an 8x8 byte block from 16-bit SRAM into the block buffer
module sram_block_unpacker
   import sram_block_unpacker_pkg::*;
#(
   parameter int AW         = 18,
   parameter int DW         = 16,
   parameter int ROW_STRIDE = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   sram_block_unpacker_if.master bus
);

   state_t            state;
   logic [AW-1:0]     addr;
   logic [AW-1:0]     row_base;
   logic [BYTE_W-1:0] word_q;
   logic [ROW_W-1:0]  i_cnt;
   logic [COL_W-1:0]  j_cnt;
   logic              accept;
   logic              write;
   logic              last;
   logic              j_wrap;
   logic [BYTE_W-1:0] byte_out;

   assign accept = (state == IDLE) && bus.start;
   assign write  = (state == HI) || (state == LO);
   assign last   = (i_cnt == ROW_W'(ROWS - 1)) && (j_cnt == COL_W'(COLS - 1));
   assign j_wrap = write && (j_cnt == COL_W'(COLS - 1));

   // j advances on every byte write, so it is even in HI and odd in LO
   sram_block_unpacker_counterr #(.SIZE(COL_W)) u_j_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (write),
      .count  (j_cnt)
   );

   sram_block_unpacker_counterr #(.SIZE(ROW_W)) u_i_counter (
      .clock  (clock),
      .reset  (reset),
      .clear  (accept),
      .enable (j_wrap),
      .count  (i_cnt)
   );

   // The next word address is settled on leaving HI so LO can issue the read
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         addr     <= '0;
         row_base <= '0;
         word_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  row_base <= bus.base_addr;
                  addr     <= bus.base_addr;
                  state    <= RD0;
               end
            end
            RD0: state <= HI;
            HI: begin
               word_q <= bus.sram_rdata[BYTE_W-1:0];
               if (j_cnt == COL_W'(COLS - 2)) begin
                  row_base <= row_base + AW'(ROW_STRIDE);
                  addr     <= row_base + AW'(ROW_STRIDE);
               end else begin
                  addr <= addr + AW'(1);
               end
               state <= LO;
            end
            LO:      state <= last ? FIN : HI;
            FIN:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      byte_out = '0;
      case (state)
         HI:      byte_out = bus.sram_rdata[DW-1 -: BYTE_W];
         LO:      byte_out = word_q;
         default: byte_out = '0;
      endcase
   end

   assign bus.sram_addr   = addr;
   assign bus.sram_ren    = (state == RD0) || ((state == LO) && !last);
   assign bus.mem32_enb   = write;
   assign bus.r_data      = byte_out;
   assign bus.in_icounter = i_cnt;
   assign bus.in_jcounter = j_cnt;
   assign bus.busy        = (state == RD0) || write;
   assign bus.done        = (state == FIN);

endmodule

// File: tb/tb_sram_block_unpacker.sv
// tb/tb_sram_block_unpacker.sv - scoreboard bench for sram_block_unpacker
module tb_sram_block_unpacker;

   localparam int AW = 18;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   sram_block_unpacker_if #(.AW(AW), .DW(16)) ifc ();
   sram_block_unpacker_if #(.AW(AW), .DW(16)) ifs ();

   sram_block_unpacker #(.AW(AW), .DW(16), .ROW_STRIDE(4)) u_dut_c (
      .clock (clk),
      .reset (rst),
      .bus   (ifc.master)
   );

   sram_block_unpacker #(.AW(AW), .DW(16), .ROW_STRIDE(160)) u_dut_s (
      .clock (clk),
      .reset (rst),
      .bus   (ifs.master)
   );

   logic          start = 1'b0;
   logic [AW-1:0] base  = '0;
   int            sel   = 0;

   assign ifc.start     = start && (sel == 0);
   assign ifs.start     = start && (sel == 1);
   assign ifc.base_addr = base;
   assign ifs.base_addr = base;

   logic [15:0] mem [int];

   function automatic logic [15:0] rd(input logic [AW-1:0] a);
      return mem.exists(int'(a)) ? mem[int'(a)] : 16'h0000;
   endfunction

   always @(posedge clk) if (ifc.sram_ren) ifc.sram_rdata <= rd(ifc.sram_addr);
   always @(posedge clk) if (ifs.sram_ren) ifs.sram_rdata <= rd(ifs.sram_addr);

   logic          m_enb, m_ren, m_busy, m_done;
   logic [7:0]    m_data;
   logic [2:0]    m_i, m_j;
   logic [AW-1:0] m_addr;

   assign m_enb  = sel ? ifs.mem32_enb   : ifc.mem32_enb;
   assign m_ren  = sel ? ifs.sram_ren    : ifc.sram_ren;
   assign m_busy = sel ? ifs.busy        : ifc.busy;
   assign m_done = sel ? ifs.done        : ifc.done;
   assign m_data = sel ? ifs.r_data      : ifc.r_data;
   assign m_i    = sel ? ifs.in_icounter : ifc.in_icounter;
   assign m_j    = sel ? ifs.in_jcounter : ifc.in_jcounter;
   assign m_addr = sel ? ifs.sram_addr   : ifc.sram_addr;

   typedef struct {
      int         cyc;
      logic [2:0] i;
      logic [2:0] j;
      logic [7:0] b;
   } wr_t;

   typedef struct {
      int            cyc;
      logic [AW-1:0] a;
   } rd_t;

   wr_t wq[$];
   rd_t rq[$];
   int  dq[$];

   function automatic int stride_of(input int s);
      return (s == 1) ? 160 : 4;
   endfunction

   // Element (i,c) comes from word base + i*stride + c/2; even c is the high byte
   task automatic push_block(input int c0, input logic [AW-1:0] b, input int stride);
      for (int i = 0; i < 8; i++) begin
         for (int w = 0; w < 4; w++) begin
            rd_t r;
            r.cyc = c0 + 1 + 2 * (4 * i + w);
            r.a   = b + AW'(i * stride + w);
            rq.push_back(r);
         end
         for (int c = 0; c < 8; c++) begin
            wr_t e;
            logic [15:0] word;
            word  = rd(b + AW'(i * stride + c / 2));
            e.cyc = c0 + 2 + 8 * i + c;
            e.i   = 3'(i);
            e.j   = 3'(c);
            e.b   = (c % 2 == 0) ? word[15:8] : word[7:0];
            wq.push_back(e);
         end
      end
      dq.push_back(c0 + 66);
   endtask

   task automatic fill(input logic [AW-1:0] b, input int stride, input bit pattern);
      for (int i = 0; i < 8; i++)
         for (int w = 0; w < 4; w++) begin
            int n;
            n = 4 * i + w;
            mem[int'(b + AW'(i * stride + w))] =
               pattern ? {8'(2 * n), 8'(2 * n + 1)} : 16'($urandom);
         end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (m_ren) begin
            if (rq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_read: addr %h at cycle %0d", m_addr, cyc);
            end else begin
               rd_t r;
               r = rq.pop_front();
               chk("read_cycle", 64'(cyc), 64'(r.cyc));
               chk("read_addr", 64'(m_addr), 64'(r.a));
            end
         end
         if (m_enb) begin
            if (wq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_write: (%0d,%0d)=%h at cycle %0d", m_i, m_j, m_data, cyc);
            end else begin
               wr_t e;
               e = wq.pop_front();
               chk("write_cycle", 64'(cyc), 64'(e.cyc));
               chk("write_ij", 64'({m_i, m_j}), 64'({e.i, e.j}));
               chk("write_data", 64'(m_data), 64'(e.b));
               chk("busy_on_write", 64'(m_busy), 64'(1));
            end
         end
         if (m_done) begin
            if (dq.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_done at cycle %0d", cyc);
            end else begin
               int d;
               d = dq.pop_front();
               chk("done_cycle", 64'(cyc), 64'(d));
               chk("busy_on_done", 64'(m_busy), 64'(0));
            end
         end
      end
   end

   task automatic run_start(input int s, input logic [AW-1:0] b, output int c0);
      @(negedge clk);
      sel   = s;
      base  = b;
      start = 1'b1;
      c0    = cyc;
      push_block(c0, b, stride_of(s));
      @(negedge clk);
      start = 1'b0;
      base  = AW'($urandom);
   endtask

   task automatic wait_cyc(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain();
      for (int t = 0; t < 400 && (wq.size() + rq.size() + dq.size()) != 0; t++)
         @(negedge clk);
      chk("queues_drained", 64'(wq.size() + rq.size() + dq.size()), 64'(0));
      repeat (4) @(negedge clk);
   endtask

   function automatic logic [63:0] out_vec();
      return 64'({m_addr, m_ren, m_enb, m_data, m_i, m_j, m_busy, m_done});
   endfunction

   initial begin
      int c0;
      logic [AW-1:0] b;

      repeat (3) @(negedge clk);
      chk("reset_outputs_c", 64'({ifc.sram_addr, ifc.sram_ren, ifc.mem32_enb, ifc.r_data,
                                  ifc.in_icounter, ifc.in_jcounter, ifc.busy, ifc.done}), 64'(0));
      chk("reset_outputs_s", 64'({ifs.sram_addr, ifs.sram_ren, ifs.mem32_enb, ifs.r_data,
                                  ifs.in_icounter, ifs.in_jcounter, ifs.busy, ifs.done}), 64'(0));
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // contiguous block with the (i,c) = 8i+c pattern
      fill(18'h00100, 4, 1'b1);
      run_start(0, 18'h00100, c0);
      drain();

      // byte order of the first word
      fill(18'h00200, 4, 1'b0);
      mem[int'(18'h00200)] = 16'hA55A;
      run_start(0, 18'h00200, c0);
      drain();

      // strided block
      fill(18'h00000, 160, 1'b0);
      run_start(1, 18'h00000, c0);
      drain();

      // address wrap
      fill(18'h3FFFE, 4, 1'b0);
      run_start(0, 18'h3FFFE, c0);
      drain();

      // start held through the block: back-to-back second block at cycle 67
      fill(18'h01000, 4, 1'b0);
      @(negedge clk);
      sel = 0; base = 18'h01000; start = 1'b1; c0 = cyc;
      push_block(c0, 18'h01000, 4);
      push_block(c0 + 67, 18'h01000, 4);
      wait_cyc(c0 + 68);
      start = 1'b0;
      drain();

      // stray start pulse during cycle 30 is ignored
      fill(18'h02000, 160, 1'b0);
      run_start(1, 18'h02000, c0);
      wait_cyc(c0 + 30);
      base = 18'h03000; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain();

      // asynchronous reset mid-block, then a fresh block
      fill(18'h04000, 4, 1'b0);
      run_start(0, 18'h04000, c0);
      wait_cyc(c0 + 20);
      rst = 1'b1;
      #1;
      chk("reset_mid_block", out_vec(), 64'(0));
      wq.delete(); rq.delete(); dq.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      fill(18'h05123, 4, 1'b0);
      run_start(0, 18'h05123, c0);
      drain();

      // randomized blocks on both strides
      for (int n = 0; n < 8; n++) begin
         int s;
         s = n % 2;
         b = AW'($urandom);
         fill(b, stride_of(s), 1'b0);
         run_start(s, b, c0);
         drain();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

endmodule
